vdp_color_mux: RTL and testbench
================================

// Module: vdp_color_mux
// PURPOSE
// - Final pixel stage of the VDP. Sits directly downstream of the background and sprite generators.
// - Selects between the background and sprite pixel per priority, then looks the result up in Game Gear colour RAM (CRAM).
// - Outputs 4-bit R/G/B with an active-pixel qualifier, windowed to the 160x144 LCD area.
// - Owns CRAM storage and its CPU write path: even-byte latch, odd-byte commit.
// PARAMETERS
// - WIN_X0  48   first visible pixel_x of the LCD window
// - WIN_W   160  LCD window width in pixels
// - WIN_Y0  24   first visible pixel_y of the LCD window
// - WIN_H   144  LCD window height in lines
// PORTS
// - clk          in   1   pixel clock, rising edge
// - rst          in   1   asynchronous active-high reset
// - pixel_x      in   10  pixel column, aligned with bg_color / spr_color
// - pixel_y      in   10  pixel line, aligned with bg_color / spr_color
// - bg_color     in   6   background CRAM byte address; bit0 always 0, bit5 = palette
// - bg_priority  in   1   background tile priority bit
// - spr_color    in   4   sprite palette index; 0 = transparent
// - cram_we      in   1   CPU CRAM byte-write strobe, one cycle per byte
// - cram_addr    in   6   CPU CRAM byte address
// - cram_data    in   8   CPU CRAM write data
// - red          out  4   pixel red
// - green        out  4   pixel green
// - blue         out  4   pixel blue
// - pixel_valid  out  1   high when red/green/blue carry an in-window pixel
// BEHAVIOUR
// - Reset (async): all 32 CRAM entries, the write latch, pipeline regs, red/green/blue and pixel_valid go to 0.
//   A reset asserted mid-write or mid-frame discards the pending latch byte.
// - CRAM layout: 32 entries x 12 bits, stored as {BBBB, GGGG, RRRR}.
//   Byte form: even byte = GGGGRRRR; odd byte = ----BBBB.
// - CPU write, cram_addr[0]=0: latch <= cram_data. CRAM is unchanged.
// - CPU write, cram_addr[0]=1: CRAM[cram_addr[5:1]] <= {cram_data[3:0], latch}.
//   The latch is used regardless of which even address loaded it. The latch is unchanged.
// - Select (stage 1, registered):
//   - bg_opaque = (bg_color[4:1] != 0).
//   - Use the sprite when spr_color != 0 AND !(bg_priority && bg_opaque).
//     Sprite index = {1'b1, spr_color}, i.e. sprites always use the upper palette.
//   - Otherwise use the background. Background index = bg_color[5:1].
//   - Window flag = pixel_x in [WIN_X0, WIN_X0+WIN_W-1] AND pixel_y in [WIN_Y0, WIN_Y0+WIN_H-1]. Compares are unsigned 10-bit.
// - Lookup (stage 2, registered): {blue, green, red} <= CRAM[index]; pixel_valid <= window flag.
//   When the window flag is 0, red/green/blue <= 0.
// - Latency: exactly 2 clk from pixel inputs to outputs. Fully pipelined, one pixel per clk, no stalls.
// - Write/read collision: if a commit and a stage-2 read hit the same entry in one cycle, the read returns the pre-write value.
//   The new value is visible from the next cycle.
// - Simultaneous even-byte latch load and stage-2 read: no interaction.
// - Window edges are inclusive of the start and exclusive of start+width.
//   Example: x=207 is visible, x=208 is not.
// TESTING
// - Reset, then write 0x2F@0x02 and 0x0A@0x03 -> CRAM[1]=0xA2F.
//   bg_color=0x02, spr=0 at (48,24) -> 2 clk later r=F g=2 b=A, pixel_valid=1.
// - Write 0x55@0x00 then 0x03@0x05 (mismatched pair) -> CRAM[2]=0x355; CRAM[0] unchanged (0).
// - Priority matrix with bg_color=0x04:
//   - spr=3, bg_priority=0 -> CRAM[19].
//   - spr=3, bg_priority=1 -> CRAM[2].
//   - spr=3, bg_priority=1, bg_color=0x00 -> CRAM[19].
//   - spr=0 -> CRAM[2].
// - Window sweep, y=24, x=47/48/207/208 -> pixel_valid 0/1/1/0, and rgb=0 when invalid.
//   Repeat with x=100 and y=23/24/167/168.
// - Collision: commit CRAM[1]=0x123 in the cycle stage 2 reads CRAM[1] (old 0xA2F) -> that output is 0xA2F, the next read is 0x123.
// - Assert rst mid-stream after an even-byte latch -> outputs 0 immediately.
//   After release, an odd write 0x07@0x03 gives CRAM[1]=0x700.

Source files
------------

// File: rtl/vdp_color_mux_if.sv
// Pixel, CRAM-write and RGB-output bundle for vdp_color_mux.
// The master drives pixels and CPU writes; the slave is the colour stage.
interface vdp_color_mux_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [5:0] bg_color;
  logic       bg_priority;
  logic [3:0] spr_color;
  logic       cram_we;
  logic [5:0] cram_addr;
  logic [7:0] cram_data;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       pixel_valid;

  modport master (
    output pixel_x, pixel_y, bg_color, bg_priority, spr_color,
    output cram_we, cram_addr, cram_data,
    input  red, green, blue, pixel_valid
  );

  modport slave (
    input  pixel_x, pixel_y, bg_color, bg_priority, spr_color,
    input  cram_we, cram_addr, cram_data,
    output red, green, blue, pixel_valid
  );
endinterface

// File: rtl/vdp_color_mux.sv
// Final VDP pixel stage: BG/sprite priority select, then Game Gear CRAM lookup.
// Two-stage pipeline; owns the 32x12 CRAM and its even-latch/odd-commit write path.
module vdp_color_mux #(
  parameter int WIN_X0 = 48,
  parameter int WIN_W  = 160,
  parameter int WIN_Y0 = 24,
  parameter int WIN_H  = 144
) (
  input  logic           clk,
  input  logic           rst,
  vdp_color_mux_if.slave bus
);

  // 11-bit bounds so start+width can never wrap the 10-bit coordinate
  localparam logic [10:0] X_LO = 11'(WIN_X0);
  localparam logic [10:0] X_HI = 11'(WIN_X0 + WIN_W);
  localparam logic [10:0] Y_LO = 11'(WIN_Y0);
  localparam logic [10:0] Y_HI = 11'(WIN_Y0 + WIN_H);

  logic [11:0] cram_q [32];
  logic [7:0]  latch_q;

  logic        bg_opaque_s;
  logic        use_spr_s;
  logic [4:0]  idx_d;
  logic        win_d;
  logic [4:0]  idx_q;
  logic        win_q;

  logic [11:0] rgb_d;
  logic [11:0] rgb_q;
  logic        valid_q;

  logic        unused_bg_lsb_s;
  assign unused_bg_lsb_s = bus.bg_color[0];

  // CPU write path: even byte parks in the latch, odd byte commits {BBBB, latch}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= 8'h00;
      for (int i = 0; i < 32; i++) begin
        cram_q[i] <= 12'h000;
      end
    end else if (bus.cram_we) begin
      if (bus.cram_addr[0] == 1'b0) begin
        latch_q <= bus.cram_data;
      end else begin
        cram_q[bus.cram_addr[5:1]] <= {bus.cram_data[3:0], latch_q};
      end
    end
  end

  // Stage-1 select: sprites live in the upper palette and lose only to an opaque priority tile
  always_comb begin
    bg_opaque_s = (bus.bg_color[4:1] != 4'h0);
    use_spr_s   = (bus.spr_color != 4'h0) && !(bus.bg_priority && bg_opaque_s);
    idx_d       = bus.bg_color[5:1];
    if (use_spr_s) begin
      idx_d = {1'b1, bus.spr_color};
    end else begin
      idx_d = bus.bg_color[5:1];
    end
    win_d = ({1'b0, bus.pixel_x} >= X_LO) && ({1'b0, bus.pixel_x} < X_HI) &&
            ({1'b0, bus.pixel_y} >= Y_LO) && ({1'b0, bus.pixel_y} < Y_HI);
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 5'd0;
      win_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      win_q <= win_d;
    end
  end

  // Stage-2 lookup; blanked outside the window
  always_comb begin
    rgb_d = 12'h000;
    if (win_q) begin
      rgb_d = cram_q[idx_q];
    end else begin
      rgb_d = 12'h000;
    end
  end

  // Stage-2 output register; a same-cycle commit is seen one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= 12'h000;
      valid_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      valid_q <= win_q;
    end
  end

  assign bus.red         = rgb_q[3:0];
  assign bus.green       = rgb_q[7:4];
  assign bus.blue        = rgb_q[11:8];
  assign bus.pixel_valid = valid_q;

endmodule

// File: tb/tb_vdp_color_mux.sv
// Randomised and directed bench for vdp_color_mux against a pixel-queue colour model.
module tb_vdp_color_mux;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] bg;
    logic       pri;
    logic [3:0] spr;
  } pix_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [11:0] cram_m [32];
  logic [7:0]  latch_m;
  pix_t        pend_q[$];
  logic [12:0] obs_v;

  vdp_color_mux_if bus ();

  vdp_color_mux #(
    .WIN_X0(48), .WIN_W(160), .WIN_Y0(24), .WIN_H(144)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t mkpix(input int x, input int y, input int bg, input int pri, input int spr);
    pix_t p;
    p.x   = 10'(x);
    p.y   = 10'(y);
    p.bg  = 6'(bg);
    p.pri = 1'(pri);
    p.spr = 4'(spr);
    return p;
  endfunction

  // Expected {valid, B, G, R} for a pixel, read from the model CRAM as it stands now
  function automatic logic [12:0] model_out(input pix_t p);
    int idx;
    bit vis;
    bit opaque;
    vis    = (p.x >= 48) && (p.x < 48 + 160) && (p.y >= 24) && (p.y < 24 + 144);
    opaque = ((p.bg / 2) % 16) != 0;
    if (p.spr != 0 && !(p.pri && opaque)) idx = 16 + p.spr;
    else                                  idx = p.bg / 2;
    if (vis) return {1'b1, cram_m[idx]};
    else     return 13'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) cram_m[i] = 12'h000;
    latch_m = 8'h00;
    pend_q.delete();
    pend_q.push_back(mkpix(0, 0, 0, 0, 0));
  endtask

  // One pixel clock: drive, predict, clock, compare against the model
  task automatic step(input pix_t p, input logic we, input int a, input int d);
    logic [12:0] exp_v;
    logic [5:0]  a6;
    logic [7:0]  d8;
    a6 = 6'(a);
    d8 = 8'(d);
    bus.pixel_x     = p.x;
    bus.pixel_y     = p.y;
    bus.bg_color    = p.bg;
    bus.bg_priority = p.pri;
    bus.spr_color   = p.spr;
    bus.cram_we     = we;
    bus.cram_addr   = a6;
    bus.cram_data   = d8;
    exp_v = model_out(pend_q.pop_front());
    pend_q.push_back(p);
    if (we) begin
      if (a6[0] == 1'b0) latch_m = d8;
      else               cram_m[a6[5:1]] = {d8[3:0], latch_m};
    end
    @(posedge clk);
    #1;
    obs_v = {bus.pixel_valid, bus.blue, bus.green, bus.red};
    check_eq("pipe", 32'(obs_v), 32'(exp_v));
    bus.cram_we = 1'b0;
  endtask

  task automatic idle(input logic we, input int a, input int d);
    step(mkpix(0, 0, 0, 0, 0), we, a, d);
  endtask

  logic [12:0] sweep_exp [8];
  int          sweep_x   [8];
  int          sweep_y   [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.pixel_x = 10'd0; bus.pixel_y = 10'd0; bus.bg_color = 6'd0;
    bus.bg_priority = 1'b0; bus.spr_color = 4'd0;
    bus.cram_we = 1'b0; bus.cram_addr = 6'd0; bus.cram_data = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", 32'({bus.pixel_valid, bus.blue, bus.green, bus.red}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write pair and lookup
    idle(1'b1, 6'h02, 8'h2F);
    idle(1'b1, 6'h03, 8'h0A);
    step(mkpix(48, 24, 6'h02, 0, 0), 1'b0, 0, 0);
    idle(1'b0, 0, 0);
    check_eq("first_px", 32'(obs_v), 32'h1A2F);

    // Mismatched even/odd pair
    idle(1'b1, 6'h00, 8'h55);
    idle(1'b1, 6'h05, 8'h03);
    step(mkpix(60, 30, 6'h04, 0, 0), 1'b0, 0, 0);
    step(mkpix(60, 30, 6'h00, 0, 0), 1'b0, 0, 0);
    check_eq("mismatch_c2", 32'(obs_v), 32'h1355);
    idle(1'b0, 0, 0);
    check_eq("mismatch_c0", 32'(obs_v), 32'h1000);

    // Priority matrix, CRAM[19] = 0x59C
    idle(1'b1, 6'h26, 8'h9C);
    idle(1'b1, 6'h27, 8'h05);
    step(mkpix(70, 40, 6'h04, 0, 3), 1'b0, 0, 0);
    step(mkpix(70, 40, 6'h04, 1, 3), 1'b0, 0, 0);
    check_eq("prio_spr", 32'(obs_v), 32'h159C);
    step(mkpix(70, 40, 6'h00, 1, 3), 1'b0, 0, 0);
    check_eq("prio_bg", 32'(obs_v), 32'h1355);
    step(mkpix(70, 40, 6'h04, 0, 0), 1'b0, 0, 0);
    check_eq("prio_transp_bg", 32'(obs_v), 32'h159C);
    idle(1'b0, 0, 0);
    check_eq("prio_nospr", 32'(obs_v), 32'h1355);

    // Window edges, CRAM[1] = 0xA2F
    sweep_x = '{47, 48, 207, 208, 100, 100, 100, 100};
    sweep_y = '{24, 24, 24, 24, 23, 24, 167, 168};
    sweep_exp = '{13'h0000, 13'h1A2F, 13'h1A2F, 13'h0000,
                  13'h0000, 13'h1A2F, 13'h1A2F, 13'h0000};
    step(mkpix(sweep_x[0], sweep_y[0], 6'h02, 0, 0), 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) step(mkpix(sweep_x[i+1], sweep_y[i+1], 6'h02, 0, 0), 1'b0, 0, 0);
      else       idle(1'b0, 0, 0);
      check_eq($sformatf("win_%0d_%0d", sweep_x[i], sweep_y[i]), 32'(obs_v), 32'(sweep_exp[i]));
    end

    // Collision: commit CRAM[1]=0x123 on the edge that reads it
    idle(1'b1, 6'h02, 8'h23);
    step(mkpix(100, 100, 6'h02, 0, 0), 1'b0, 0, 0);
    idle(1'b1, 6'h03, 8'h01);
    check_eq("collide_old", 32'(obs_v), 32'h1A2F);
    step(mkpix(100, 100, 6'h02, 0, 0), 1'b0, 0, 0);
    idle(1'b0, 0, 0);
    check_eq("collide_new", 32'(obs_v), 32'h1123);

    // Mid-stream async reset discards latch and CRAM
    step(mkpix(100, 100, 6'h02, 0, 0), 1'b1, 6'h00, 8'h44);
    step(mkpix(100, 100, 6'h02, 0, 0), 1'b0, 0, 0);
    check_eq("pre_rst", 32'(obs_v), 32'h1123);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", 32'({bus.pixel_valid, bus.blue, bus.green, bus.red}), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1, 6'h03, 8'h07);
    step(mkpix(100, 100, 6'h02, 0, 0), 1'b0, 0, 0);
    idle(1'b0, 0, 0);
    check_eq("post_rst", 32'(obs_v), 32'h1700);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      pix_t p;
      p = mkpix($urandom_range(40, 215), $urandom_range(18, 174),
                $urandom_range(0, 63) & 32'h3E, $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15));
      step(p, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
